led_stream_player: RTL

//  Consumer end of the tutorial FIFO path: drains a valid/ready data stream (FIFO read side)
//  and presents each word on the board LEDs for a fixed show time, then a blank gap.

---
 rtl/led_player_pkg.sv | 27 ++
 rtl/led_stream_player.sv | 93 +++++++++
 2 files changed

// File: rtl/led_player_pkg.sv
// Shared types and elaboration helpers for the LED stream player.
// Time-to-cycle conversion rounds to the nearest whole clock cycle.
package led_player_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } player_state_t;

   localparam int OffPatternW = 64;

   function automatic int time_to_cycles(input real freq, input real t);
      return int'($rtoi(freq * t + 0.5));
   endfunction

   // All-ones for active-low LEDs, all-zeros otherwise; callers truncate to their width.
   function automatic logic [OffPatternW-1:0] off_pattern(input int width, input bit active_low);
      logic [OffPatternW-1:0] p;
      p = '0;
      for (int i = 0; i < OffPatternW; i++) begin
         if (active_low && (i < width)) p[i] = 1'b1;
      end
      return p;
   endfunction

endpackage

// File: rtl/led_stream_player.sv
// Drains a valid/ready stream and shows each word on the LEDs for a fixed time,
// followed by an optional blank gap; Pause freezes playback.
module led_stream_player
   import led_player_pkg::*;
#(
   parameter real ClkFrequency_g = 10.0e6,
   parameter real ShowTime_g     = 0.5,
   parameter real GapTime_g      = 0.1,
   parameter int  Width_g        = 4,
   parameter bit  LedActiveLow_g = 1'b1
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic [Width_g-1:0] In_Data,
   input  logic               In_Valid,
   output logic               In_Ready,
   input  logic               Pause,
   output logic [Width_g-1:0] Led,
   output logic               Busy,
   output logic [7:0]         Count
);

   localparam int ShowCycles = time_to_cycles(ClkFrequency_g, ShowTime_g);
   localparam int GapCycles  = time_to_cycles(ClkFrequency_g, GapTime_g);
   localparam int MaxCycles  = (ShowCycles > GapCycles) ? ShowCycles : GapCycles;
   localparam int TimerW     = (MaxCycles < 1) ? 1 : $clog2(MaxCycles + 1);

   localparam logic [TimerW-1:0]  ShowLoad   = TimerW'(ShowCycles - 1);
   localparam logic [TimerW-1:0]  GapLoad    = (GapCycles > 0) ? TimerW'(GapCycles - 1) : '0;
   localparam logic [Width_g-1:0] OffPattern = Width_g'(off_pattern(Width_g, LedActiveLow_g));

   if (ShowCycles < 1) begin : g_show_check
      $fatal(1, "led_stream_player: show time must be at least one clock cycle");
   end
   if (GapCycles < 0) begin : g_gap_check
      $fatal(1, "led_stream_player: gap time must not be negative");
   end

   player_state_t      state;
   player_state_t      state_nxt;
   logic [TimerW-1:0]  timer;
   logic [Width_g-1:0] led_nxt;
   logic               accept;
   logic               expire;

   // Next-state logic: a phase ends on the first non-paused cycle with the timer at zero.
   always_comb begin
      state_nxt = state;
      expire    = (state != IDLE) && !Pause && (timer == '0);
      unique case (state)
         IDLE:    if (accept) state_nxt = SHOW;
         SHOW:    if (expire) state_nxt = (GapCycles > 0) ? GAP : IDLE;
         GAP:     if (expire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: the Led register doubles as the latched word, so it only
   // changes on acceptance or when the show phase ends.
   always_comb begin
      In_Ready = (state == IDLE) && !Pause && !Rst;
      accept   = In_Valid && In_Ready;
      led_nxt  = Led;
      if (accept) begin
         led_nxt = LedActiveLow_g ? ~In_Data : In_Data;
      end else if ((state == SHOW) && expire) begin
         led_nxt = OffPattern;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
         timer <= '0;
         Led   <= OffPattern;
         Busy  <= 1'b0;
         Count <= 8'd0;
      end else begin
         state <= state_nxt;
         Busy  <= (state_nxt != IDLE);
         Led   <= led_nxt;
         if (accept) begin
            timer <= ShowLoad;
            Count <= Count + 8'd1;
         end else if ((state == SHOW) && (state_nxt == GAP)) begin
            timer <= GapLoad;
         end else if ((state != IDLE) && !Pause && (timer != '0)) begin
            timer <= timer - TimerW'(1);
         end
      end
   end

endmodule
